rr_lock_arbiter: RTL and testbench

Round-robin arbiter with grant locking. It shares one multi-cycle resource, such as a shared memory port or a long-latency functional unit, among NUM_REQUESTERS requesters. A winner keeps the grant until it signals done, or until a hold-time limit revokes it. The grant is presented both one-hot and as an encoded index, so downstream muxes and tag fields can use whichever form they need.

---
 rtl/rr_lock_arbiter_if.sv | 40 ++++
 rtl/rr_lock_arbiter.sv | 146 ++++++++++++++
 tb/tb_rr_lock_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between a set of requesters and rr_lock_arbiter.
//   request     : per-requester request level (driven by requesters)
//   done        : current holder releases the grant (driven by requesters)
//   grant_oh    : one-hot grant, zero when nothing is granted
//   grant_idx   : encoded index of the grant_oh bit, zero when not granted
//   grant_valid : high while a grant is held
//   revoked     : one-cycle pulse following a forced (hold-limit) revoke
interface rr_lock_arbiter_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned IDX_WIDTH      = $clog2(NUM_REQUESTERS)
);

  logic [NUM_REQUESTERS-1:0] request;
  logic                      done;
  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic [IDX_WIDTH-1:0]      grant_idx;
  logic                      grant_valid;
  logic                      revoked;

  // Requester side.
  modport master (
    output request,
    output done,
    input  grant_oh,
    input  grant_idx,
    input  grant_valid,
    input  revoked
  );

  // Arbiter side.
  modport slave (
    input  request,
    input  done,
    output grant_oh,
    output grant_idx,
    output grant_valid,
    output revoked
  );

endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking for one shared multi-cycle resource.
// A winner keeps the grant until it pulses done, or until HOLD_LIMIT granted
// cycles have elapsed, in which case the grant is revoked and revoked pulses.
// All outputs are registered; there is no combinational path from request
// or done to any output.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : rr_lock_arbiter_if.slave (request/done in, grant_oh/grant_idx/
//           grant_valid/revoked out)
// Parameters: NUM_REQUESTERS >= 2, HOLD_LIMIT in [0, 65535] (0 = no limit).
module rr_lock_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned IDX_WIDTH      = $clog2(NUM_REQUESTERS),
  parameter int unsigned HOLD_LIMIT     = 16
) (
  input  logic                clk,
  input  logic                reset,
  rr_lock_arbiter_if.slave    bus
);

  localparam int unsigned HCNT_WIDTH = 16;
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_REQUESTERS - 1);
  localparam logic [HCNT_WIDTH-1:0] LIMIT_VAL = HCNT_WIDTH'(HOLD_LIMIT);
  localparam logic [HCNT_WIDTH-1:0] HCNT_MAX  = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_WIDTH-1:0]      ptr_q, ptr_d;
  logic [HCNT_WIDTH-1:0]     hcnt_q, hcnt_d;
  logic [NUM_REQUESTERS-1:0] grant_oh_q, grant_oh_d;
  logic [IDX_WIDTH-1:0]      grant_idx_q, grant_idx_d;
  logic                      grant_valid_q, grant_valid_d;
  logic                      revoked_q, revoked_d;

  logic [IDX_WIDTH-1:0]      pick_idx;
  logic [IDX_WIDTH-1:0]      ptr_after_holder;
  logic                      limit_hit;

  // First set request bit scanning upward from p, wrapping at N-1 to 0.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(
    input logic [NUM_REQUESTERS-1:0] req,
    input logic [IDX_WIDTH-1:0]      p
  );
    logic [IDX_WIDTH-1:0] sel;
    logic [IDX_WIDTH-1:0] cand_idx;
    logic                 found;
    int unsigned          cand;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      cand     = (32'(p) + i) % NUM_REQUESTERS;
      cand_idx = IDX_WIDTH'(cand);
      if (!found && req[cand_idx]) begin
        sel   = cand_idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Round-robin choice and pointer advance past the current holder.
  always_comb begin
    pick_idx         = rr_pick(bus.request, ptr_q);
    ptr_after_holder = (grant_idx_q == LAST_IDX) ? '0
                                                 : grant_idx_q + IDX_WIDTH'(1);
    limit_hit        = (HOLD_LIMIT != 0) && (hcnt_q == LIMIT_VAL);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hcnt_q        <= '0;
      grant_oh_q    <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      revoked_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hcnt_q        <= hcnt_d;
      grant_oh_q    <= grant_oh_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      revoked_q     <= revoked_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hcnt_d        = hcnt_q;
    grant_oh_d    = grant_oh_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    revoked_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_oh_d    = '0;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
        // done is meaningless here and deliberately not looked at.
        if (|bus.request) begin
          state_d       = GRANTED;
          grant_idx_d   = pick_idx;
          grant_oh_d    = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << pick_idx;
          grant_valid_d = 1'b1;
          hcnt_d        = HCNT_WIDTH'(1);
        end
      end

      GRANTED: begin
        // request is ignored while locked; only done or the limit release.
        if (bus.done || limit_hit) begin
          state_d       = IDLE;
          ptr_d         = ptr_after_holder;
          hcnt_d        = '0;
          grant_oh_d    = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          // done in the same cycle as the limit is a normal release.
          revoked_d     = !bus.done;
        end else if (hcnt_q != HCNT_MAX) begin
          hcnt_d = hcnt_q + HCNT_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.grant_oh    = grant_oh_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.revoked     = revoked_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (N=4, HOLD_LIMIT=4). The stimulus
// process drives one cycle of inputs per step and queues the outputs
// expected after that clock edge; a monitor pops and compares after every
// rising edge.
module tb_rr_lock_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned LIMIT = 4;

  typedef struct {
    logic          valid;
    logic [N-1:0]  oh;
    logic [IW-1:0] idx;
    logic          rev;
    string         name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  rr_lock_arbiter_if #(.NUM_REQUESTERS(N), .IDX_WIDTH(IW)) bus ();

  rr_lock_arbiter #(
    .NUM_REQUESTERS(N),
    .IDX_WIDTH     (IW),
    .HOLD_LIMIT    (LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next rising edge and queue the outputs expected
  // right after it.
  task automatic step(input logic rst, input logic [N-1:0] req,
                      input logic dn, input logic ev, input int unsigned ei,
                      input logic er, input string nm);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    bus.request = req;
    bus.done    = dn;
    e.valid = ev;
    e.idx   = ev ? IW'(ei) : '0;
    e.oh    = ev ? (N'(1) << ei) : '0;
    e.rev   = er;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every cycle's outputs against the scoreboard head.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (bus.grant_valid !== mon_e.valid || bus.grant_oh !== mon_e.oh ||
          bus.grant_idx !== mon_e.idx || bus.revoked !== mon_e.rev) begin
        miscompares++;
        $display("FAIL %s: got valid=%b oh=%b idx=%0d rev=%b, want valid=%b oh=%b idx=%0d rev=%b",
                 mon_e.name, bus.grant_valid, bus.grant_oh, bus.grant_idx,
                 bus.revoked, mon_e.valid, mon_e.oh, mon_e.idx, mon_e.rev);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.request = '0;
    bus.done    = 1'b0;

    // Rotation with all requesters active.
    step(1, 4'b1111, 0, 0, 0, 0, "rst_a");
    step(1, 4'b1111, 0, 0, 0, 0, "rst_b");
    step(0, 4'b1111, 0, 1, 0, 0, "rot_g0");
    step(0, 4'b1111, 0, 1, 0, 0, "rot_hold0");
    step(0, 4'b1111, 1, 0, 0, 0, "rot_rel0");
    step(0, 4'b1111, 0, 1, 1, 0, "rot_g1");
    step(0, 4'b1111, 1, 0, 0, 0, "rot_rel1");
    step(0, 4'b1111, 0, 1, 2, 0, "rot_g2");
    step(0, 4'b1111, 1, 0, 0, 0, "rot_rel2");
    step(0, 4'b1111, 0, 1, 3, 0, "rot_g3");
    step(0, 4'b1111, 1, 0, 0, 0, "rot_rel3");
    step(0, 4'b1111, 0, 1, 0, 0, "rot_wrap_g0");
    step(0, 4'b0000, 1, 0, 0, 0, "rot_rel_last");

    // Lone requester 2; dropping request does not release.
    step(1, 4'b0000, 0, 0, 0, 0, "rst_lone");
    step(0, 4'b0100, 0, 1, 2, 0, "lone_g2");
    step(0, 4'b0000, 0, 1, 2, 0, "lone_drop_hold");
    step(0, 4'b0000, 1, 0, 0, 0, "lone_rel");
    step(0, 4'b0010, 0, 1, 1, 0, "lone_next_g1");
    step(0, 4'b0000, 1, 0, 0, 0, "lone_rel1");

    // Pointer wrap: grant 2 -> ptr 3; 1001 picks 3, then wraps to 0.
    step(0, 4'b0100, 0, 1, 2, 0, "wrap_g2");
    step(0, 4'b0000, 1, 0, 0, 0, "wrap_rel2");
    step(0, 4'b1001, 0, 1, 3, 0, "wrap_g3");
    step(0, 4'b1001, 1, 0, 0, 0, "wrap_rel3");
    step(0, 4'b1001, 0, 1, 0, 0, "wrap_g0");
    step(0, 4'b0000, 1, 0, 0, 0, "wrap_rel0");

    // Forced revoke after exactly LIMIT granted cycles; ptr now 1.
    step(0, 4'b0010, 0, 1, 1, 0, "rv_c1");
    step(0, 4'b0110, 0, 1, 1, 0, "rv_c2");
    step(0, 4'b0110, 0, 1, 1, 0, "rv_c3");
    step(0, 4'b0110, 0, 1, 1, 0, "rv_c4");
    step(0, 4'b0110, 0, 0, 0, 1, "rv_pulse");
    step(0, 4'b0110, 0, 1, 2, 0, "rv_next_g2");
    step(0, 4'b0000, 1, 0, 0, 0, "rv_rel2");

    // done coincides with the limit: plain release, no revoke pulse.
    step(0, 4'b0100, 0, 1, 2, 0, "dl_c1");
    step(0, 4'b0100, 0, 1, 2, 0, "dl_c2");
    step(0, 4'b0100, 0, 1, 2, 0, "dl_c3");
    step(0, 4'b0100, 0, 1, 2, 0, "dl_c4");
    step(0, 4'b0100, 1, 0, 0, 0, "dl_rel_norev");
    // done in IDLE is ignored; ptr stays 3.
    step(0, 4'b0000, 1, 0, 0, 0, "idle_done_a");
    step(0, 4'b0000, 1, 0, 0, 0, "idle_done_b");
    step(0, 4'b1111, 0, 1, 3, 0, "idle_done_g3");

    // Reset mid-grant beats a simultaneous done; ptr returns to 0.
    step(0, 4'b1111, 0, 1, 3, 0, "mid_hold3");
    step(1, 4'b1111, 1, 0, 0, 0, "mid_reset");
    step(0, 4'b1111, 0, 1, 0, 0, "mid_post_g0");
    step(0, 4'b0000, 1, 0, 0, 0, "mid_rel");

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0",
               exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
